// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronised rx, OVERSAMPLE x baud tick, samples at bit centres, LSB first.
// Latency: rx_valid/frame_err one clk after the mid-stop tick; no backpressure, data must be taken on rx_valid.
module uart_rx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err
);
    localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [SW-1:0] S_HALF   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic          rx_meta_q, rx_meta_d;
    logic          rx_s_q, rx_s_d;
    logic          rx_d_q, rx_d_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [SW-1:0] s_cnt_q, s_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    data_q, data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          rx_busy_q, rx_busy_d;
    logic          tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_d_q      <= 1'b1;
            div_cnt_q   <= '0;
            s_cnt_q     <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            rx_busy_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            rx_d_q      <= rx_d_d;
            div_cnt_q   <= div_cnt_d;
            s_cnt_q     <= s_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            rx_busy_q   <= rx_busy_d;
        end
    end

    // Divider free-runs only inside a frame, so IDLE->START always starts from a clean phase.
    assign tick = (state_q != IDLE) && (div_cnt_q == DIV_LAST);

    always_comb begin
        rx_meta_d   = rx;
        rx_s_d      = rx_meta_q;
        rx_d_d      = rx_s_q;
        state_d     = state_q;
        div_cnt_d   = '0;
        s_cnt_d     = s_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        data_d      = data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        if (state_q != IDLE && !tick) begin
            div_cnt_d = div_cnt_q + DW'(1);
        end
        case (state_q)
            IDLE: begin
                s_cnt_d = '0;
                if (rx_d_q && !rx_s_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    if (s_cnt_q == S_HALF) begin
                        s_cnt_d   = '0;
                        bit_cnt_d = '0;
                        state_d   = rx_s_q ? IDLE : DATA;
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_cnt_q == S_LAST) begin
                        shreg_d = {rx_s_q, shreg_q[7:1]};
                        s_cnt_d = '0;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_cnt_q == S_LAST) begin
                        // Leave at mid-stop so a back-to-back start edge is not missed.
                        state_d = IDLE;
                        if (rx_s_q) begin
                            data_d     = shreg_q;
                            rx_valid_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        rx_busy_d = (state_d != IDLE);
    end

    assign data      = data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = rx_busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at a scaled clock (64 clk/bit): a frame-level model queue is checked every cycle,
// plus literal expectations after each directed scenario.
module tb_uart_rx;
    localparam int CLK_FREQ = 614400;
    localparam int BAUD     = 9600;
    localparam int OS       = 16;
    localparam int BIT      = (CLK_FREQ / (BAUD * OS)) * OS;
    // Start drive -> pulse: 2 sync FFs + edge register + 9.5 bit periods.
    localparam int LAT_MIN  = (BIT * 19) / 2 - 2;
    localparam int LAT_MAX  = (BIT * 19) / 2 + 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       rx_valid, rx_busy, frame_err;

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS)) dut (
        .clk(clk), .rst(rst), .rx(rx), .data(data),
        .rx_valid(rx_valid), .rx_busy(rx_busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       err;
        logic [7:0] b;
        int         t0;
    } exp_t;

    exp_t       q[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         n_valid = 0;
    int         n_err = 0;
    logic [7:0] model_data = 8'h00;
    logic       rst_seen = 1'b1;
    logic       prev_pulse = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle compare against the frame queue.
    always @(negedge clk) begin
        exp_t e;
        if (rst_seen) begin
            model_data = 8'h00;
            check("reset_valid", {31'd0, rx_valid}, 0);
            check("reset_err", {31'd0, frame_err}, 0);
            check("reset_busy", {31'd0, rx_busy}, 0);
        end else begin
            if (rx_valid && frame_err) check("exclusive", 1, 0);
            if ((rx_valid || frame_err) && prev_pulse) check("pulse_width", 2, 1);
            if (rx_valid || frame_err) begin
                check("busy_at_pulse", {31'd0, rx_busy}, 0);
                if (q.size() == 0) begin
                    check("unexpected_pulse", {30'd0, rx_valid, frame_err}, 0);
                end else begin
                    e = q.pop_front();
                    check("pulse_kind", {31'd0, frame_err}, {31'd0, e.err});
                    total++;
                    if (cyc - e.t0 < LAT_MIN || cyc - e.t0 > LAT_MAX) begin
                        bad++;
                        $display("FAIL pulse_time: got %0d clk expected %0d..%0d", cyc - e.t0, LAT_MIN, LAT_MAX);
                    end
                    if (rx_valid && !e.err) model_data = e.b;
                end
                if (rx_valid) n_valid++;
                if (frame_err) n_err++;
            end
        end
        check("data", {24'd0, data}, {24'd0, model_data});
        prev_pulse = rx_valid || frame_err;
        rst_seen   = rst;
    end

    task automatic drive(input logic val, input int n);
        #1 rx = val;
        repeat (n) @(posedge clk);
    endtask

    // Caller is positioned just after a posedge; frames chain with no gap.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bit_len, input logic expect_it);
        exp_t e;
        #1 rx = 1'b0;
        if (expect_it) begin
            e.err = !stop_bit;
            e.b   = b;
            e.t0  = cyc;
            q.push_back(e);
        end
        repeat (bit_len) @(posedge clk);
        for (int i = 0; i < 8; i++) drive(b[i], bit_len);
        drive(stop_bit, bit_len);
    endtask

    initial begin
        logic [7:0] r;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);

        // 1: single frame, busy observed mid-frame
        fork
            send_frame(8'hA5, 1'b1, BIT, 1'b1);
            begin
                repeat (BIT * 5) @(negedge clk);
                check("t1_busy_mid", {31'd0, rx_busy}, 1);
            end
        join
        drive(1'b1, 2 * BIT);
        check("t1_data", {24'd0, data}, 32'hA5);
        check("t1_nvalid", n_valid, 1);
        check("t1_busy_idle", {31'd0, rx_busy}, 0);

        // 2: back-to-back frames
        send_frame(8'h00, 1'b1, BIT, 1'b1);
        send_frame(8'hFF, 1'b1, BIT, 1'b1);
        send_frame(8'h55, 1'b1, BIT, 1'b1);
        drive(1'b1, 2 * BIT);
        check("t2_nvalid", n_valid, 4);
        check("t2_data", {24'd0, data}, 32'h55);

        // 3: short low glitch rejected at mid-start
        drive(1'b0, BIT / 4);
        fork
            drive(1'b1, 3 * BIT);
            begin
                repeat (BIT / 8) @(negedge clk);
                check("t3_busy_high", {31'd0, rx_busy}, 1);
                repeat (BIT) @(negedge clk);
                check("t3_busy_low", {31'd0, rx_busy}, 0);
            end
        join
        check("t3_nvalid", n_valid, 4);
        check("t3_nerr", n_err, 0);

        // 4: bad stop bit
        send_frame(8'h3C, 1'b0, BIT, 1'b1);
        drive(1'b1, 2 * BIT);
        check("t4_nerr", n_err, 1);
        check("t4_nvalid", n_valid, 4);
        check("t4_data_held", {24'd0, data}, 32'h55);

        // 5: reset during bit 4, held until the aborted frame has left the line
        fork
            send_frame(8'hC3, 1'b1, BIT, 1'b0);
            begin
                repeat (BIT * 5 + BIT / 2) @(posedge clk);
                #1 rst = 1'b1;
            end
        join
        #1 rst = 1'b0;
        repeat (BIT) @(posedge clk);
        check("t5_data_reset", {24'd0, data}, 32'h00);
        send_frame(8'h81, 1'b1, BIT, 1'b1);
        drive(1'b1, 2 * BIT);
        check("t5_data", {24'd0, data}, 32'h81);
        check("t5_nvalid", n_valid, 5);

        // 6: +/-3% baud error, then random back-to-back bytes
        send_frame(8'h96, 1'b1, BIT - 2, 1'b1);
        drive(1'b1, 2 * BIT);
        check("t6_fast", {24'd0, data}, 32'h96);
        send_frame(8'h96, 1'b1, BIT + 2, 1'b1);
        drive(1'b1, 2 * BIT);
        check("t6_slow", {24'd0, data}, 32'h96);
        for (int i = 0; i < 24; i++) begin
            r = 8'($urandom_range(0, 255));
            send_frame(r, 1'b1, BIT, 1'b1);
        end
        drive(1'b1, 2 * BIT);
        check("t6_nvalid", n_valid, 31);
        check("end_nerr", n_err, 1);
        check("end_queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
